// File: rtl/pv2byp_muldiv_wb_queue.sv
// pv2byp_muldiv_wb_queue
//
// Pairs in-order 64-bit results from the pipelined multiply/divide unit with
// the writeback tags {waddr, sel} that were recorded when each request issued.
// It produces one 32-bit register-file write per result.
//
// Ports
//   clk, reset             core clock, synchronous active-high reset
//   tag_val/tag_rdy        tag enqueue handshake from issue
//   tag_waddr, tag_sel     destination register, result half (1 = upper 32 bits)
//   muldivresp_msg_result  64-bit muldiv result {hi/rem, lo/quot-or-product}
//   muldivresp_val/rdy     result handshake from the muldiv unit
//   wb_val/wb_rdy          writeback handshake to the X/W mux
//   wb_waddr, wb_data      registered writeback address and data
//   outstanding            tags enqueued and not yet paired with a result
module pv2byp_muldiv_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tag_val,
    output logic                     tag_rdy,
    input  logic [4:0]               tag_waddr,
    input  logic                     tag_sel,
    input  logic [63:0]              muldivresp_msg_result,
    input  logic                     muldivresp_val,
    output logic                     muldivresp_rdy,
    output logic                     wb_val,
    input  logic                     wb_rdy,
    output logic [4:0]               wb_waddr,
    output logic [31:0]              wb_data,
    output logic [$clog2(DEPTH):0]   outstanding
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] EMPTY_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PINC_C  = {{(PW-1){1'b0}}, 1'b1};

    // Tag storage and queue bookkeeping
    logic [4:0]    waddr_q_r [DEPTH];
    logic          sel_q_r   [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;

    // Output slot
    logic          wb_val_r;
    logic [4:0]    wb_waddr_r;
    logic [31:0]   wb_data_r;

    // Handshake terms
    logic          tag_rdy_s;
    logic          resp_rdy_s;
    logic          enq_s;
    logic          fire_s;
    logic          drain_s;
    logic [4:0]    head_waddr_s;
    logic          head_sel_s;
    logic [31:0]   sel_data_s;

    // Full check ignores a same-cycle dequeue: no full-bypass path.
    assign tag_rdy_s    = (count_r != FULL_C);
    // Accept a result only when a tag is waiting and the slot is free or draining.
    assign resp_rdy_s   = (count_r != EMPTY_C) && (!wb_val_r || wb_rdy);
    assign enq_s        = tag_val && tag_rdy_s;
    assign fire_s       = muldivresp_val && resp_rdy_s;
    assign drain_s      = wb_val_r && wb_rdy;

    assign head_waddr_s = waddr_q_r[head_r];
    assign head_sel_s   = sel_q_r[head_r];

    // Select the result half named by the head tag
    always_comb begin
        sel_data_s = 32'h0000_0000;
        if (head_sel_s) begin
            sel_data_s = muldivresp_msg_result[63:32];
        end else begin
            sel_data_s = muldivresp_msg_result[31:0];
        end
    end

    // Occupancy next-state: simultaneous enq and deq leave the count unchanged
    always_comb begin
        count_nxt_s = count_r;
        case ({enq_s, fire_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Tag storage write at the tail; entries are cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q_r[i] <= 5'd0;
                sel_q_r[i]   <= 1'b0;
            end
        end else if (enq_s) begin
            waddr_q_r[tail_r] <= tag_waddr;
            sel_q_r[tail_r]   <= tag_sel;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= EMPTY_C;
        end else begin
            if (enq_s) begin
                tail_r <= tail_r + PINC_C;
            end
            if (fire_s) begin
                head_r <= head_r + PINC_C;
            end
            count_r <= count_nxt_s;
        end
    end

    // Output slot: load on fire (replacing a draining entry), clear valid on drain only
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_val_r   <= 1'b0;
            wb_waddr_r <= 5'd0;
            wb_data_r  <= 32'h0000_0000;
        end else if (fire_s) begin
            wb_val_r   <= 1'b1;
            wb_waddr_r <= head_waddr_s;
            wb_data_r  <= sel_data_s;
        end else if (drain_s) begin
            wb_val_r   <= 1'b0;
        end
    end

    assign tag_rdy        = tag_rdy_s;
    assign muldivresp_rdy = resp_rdy_s;
    assign wb_val         = wb_val_r;
    assign wb_waddr       = wb_waddr_r;
    assign wb_data        = wb_data_r;
    assign outstanding    = count_r;

endmodule

// File: tb/tb_pv2byp_muldiv_wb_queue.sv
// Testbench for pv2byp_muldiv_wb_queue: directed stimulus, expected writebacks
// pushed into a scoreboard queue, popped by a separate monitor on each drain.
module tb_pv2byp_muldiv_wb_queue;

    logic        clk;
    logic        reset;
    logic        tag_val;
    logic        tag_rdy;
    logic [4:0]  tag_waddr;
    logic        tag_sel;
    logic [63:0] muldivresp_msg_result;
    logic        muldivresp_val;
    logic        muldivresp_rdy;
    logic        wb_val;
    logic        wb_rdy;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_data;
    logic [2:0]  outstanding;

    int checks;
    int errors;
    logic [36:0] exp_q [$];

    pv2byp_muldiv_wb_queue #(.DEPTH(4)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .tag_val               (tag_val),
        .tag_rdy               (tag_rdy),
        .tag_waddr             (tag_waddr),
        .tag_sel               (tag_sel),
        .muldivresp_msg_result (muldivresp_msg_result),
        .muldivresp_val        (muldivresp_val),
        .muldivresp_rdy        (muldivresp_rdy),
        .wb_val                (wb_val),
        .wb_rdy                (wb_rdy),
        .wb_waddr              (wb_waddr),
        .wb_data               (wb_data),
        .outstanding           (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted writeback is compared against the scoreboard head
    always @(negedge clk) begin
        if (!reset && wb_val && wb_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got waddr=%0d data=%h expected none", wb_waddr, wb_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({wb_waddr, wb_data} !== e) begin
                    errors++;
                    $display("FAIL wb_pair: got waddr=%0d data=%h expected waddr=%0d data=%h",
                             wb_waddr, wb_data, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tag(input logic [4:0] w, input logic s);
        tag_val   = 1'b1;
        tag_waddr = w;
        tag_sel   = s;
        tick();
        tag_val   = 1'b0;
    endtask

    // Present one result until accepted (bounded); optionally record the expected write
    task automatic do_resp(input logic [63:0] res, input bit push, input logic [4:0] ew,
                           input logic [31:0] ed, output int waited);
        if (push) exp_q.push_back({ew, ed});
        muldivresp_val        = 1'b1;
        muldivresp_msg_result = res;
        waited = 0;
        @(negedge clk);
        while (!muldivresp_rdy && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (!muldivresp_rdy) check("resp_timeout", 32'(muldivresp_rdy), 32'd1);
        @(posedge clk);
        #1;
        muldivresp_val = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tag_rdy"}, 32'(tag_rdy), 32'd1);
        check({tag, "_resp_rdy"}, 32'(muldivresp_rdy), 32'd0);
        check({tag, "_wb_val"}, 32'(wb_val), 32'd0);
        check({tag, "_wb_waddr"}, 32'(wb_waddr), 32'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
        check({tag, "_outstanding"}, 32'(outstanding), 32'd0);
    endtask

    initial begin
        int w;
        logic [4:0]  ew;
        logic        es;
        logic [63:0] res;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        tag_val = 1'b0;
        tag_waddr = 5'd0;
        tag_sel = 1'b0;
        muldivresp_msg_result = 64'd0;
        muldivresp_val = 1'b0;
        wb_rdy = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        tick();

        // Single rem: upper half selected
        do_tag(5'd7, 1'b1);
        do_resp(64'h0000002e_0000000a, 1'b1, 5'd7, 32'h0000002e, w);
        check("rem_latency_wait", 32'(w), 32'd0);
        check("rem_wb_val", 32'(wb_val), 32'd1);
        check("rem_wb_waddr", 32'(wb_waddr), 32'd7);
        check("rem_wb_data", wb_data, 32'h0000002e);
        tick();

        // Mixed stream, back-to-back results
        do_tag(5'd3, 1'b0);
        do_tag(5'd4, 1'b1);
        do_tag(5'd5, 1'b0);
        do_resp(64'hffffffff_ffffffc0, 1'b1, 5'd3, 32'hffffffc0, w);
        check("mix0_wait", 32'(w), 32'd0);
        do_resp(64'hffffcc8e_ffffdf75, 1'b1, 5'd4, 32'hffffcc8e, w);
        check("mix1_wait", 32'(w), 32'd0);
        do_resp(64'h0000227f_00012a90, 1'b1, 5'd5, 32'h00012a90, w);
        check("mix2_wait", 32'(w), 32'd0);
        tick();
        tick();

        // Full queue
        do_tag(5'd10, 1'b0);
        do_tag(5'd11, 1'b0);
        do_tag(5'd12, 1'b0);
        do_tag(5'd13, 1'b0);
        check("full_tag_rdy", 32'(tag_rdy), 32'd0);
        check("full_outstanding", 32'(outstanding), 32'd4);
        tag_val = 1'b1;
        tag_waddr = 5'd31;
        tag_sel = 1'b1;
        tick();
        tag_val = 1'b0;
        check("fifth_rejected", 32'(outstanding), 32'd4);
        do_resp(64'h11111111_0000aaaa, 1'b1, 5'd10, 32'h0000aaaa, w);
        check("full_release_tag_rdy", 32'(tag_rdy), 32'd1);
        check("full_release_outstanding", 32'(outstanding), 32'd3);

        // Wrap: simultaneous enq/deq for 10 cycles; heads 11,12,13 then 20..26
        for (int k = 0; k < 10; k++) begin
            if (k < 3) begin
                ew = 5'(11 + k);
                es = 1'b0;
            end else begin
                ew = 5'(20 + k - 3);
                es = ((k - 3) % 2) == 1;
            end
            res = {32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k)};
            exp_q.push_back({ew, es ? res[63:32] : res[31:0]});
            tag_val = 1'b1;
            tag_waddr = 5'(20 + k);
            tag_sel = (k % 2) == 1;
            muldivresp_val = 1'b1;
            muldivresp_msg_result = res;
            @(negedge clk);
            check("wrap_resp_rdy", 32'(muldivresp_rdy), 32'd1);
            check("wrap_tag_rdy", 32'(tag_rdy), 32'd1);
            tick();
        end
        tag_val = 1'b0;
        muldivresp_val = 1'b0;
        check("wrap_outstanding", 32'(outstanding), 32'd3);
        do_resp(64'h0000001b_000000b1, 1'b1, 5'd27, 32'h0000001b, w);
        do_resp(64'h000000ff_0000001c, 1'b1, 5'd28, 32'h0000001c, w);
        do_resp(64'h0000001d_00000000, 1'b1, 5'd29, 32'h0000001d, w);
        check("wrap_drained", 32'(outstanding), 32'd0);
        tick();

        // Backpressure
        wb_rdy = 1'b0;
        do_tag(5'd1, 1'b0);
        do_tag(5'd2, 1'b1);
        exp_q.push_back({5'd1, 32'h0000beef});
        exp_q.push_back({5'd2, 32'h00c0ffee});
        muldivresp_val = 1'b1;
        muldivresp_msg_result = 64'h12345678_0000beef;
        @(negedge clk);
        check("bp_first_rdy", 32'(muldivresp_rdy), 32'd1);
        tick();
        muldivresp_msg_result = 64'h00c0ffee_87654321;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_resp_rdy_low", 32'(muldivresp_rdy), 32'd0);
            check("bp_wb_val", 32'(wb_val), 32'd1);
            check("bp_wb_waddr", 32'(wb_waddr), 32'd1);
            check("bp_wb_data", wb_data, 32'h0000beef);
            tick();
        end
        wb_rdy = 1'b1;
        @(negedge clk);
        check("bp_release_rdy", 32'(muldivresp_rdy), 32'd1);
        tick();
        muldivresp_val = 1'b0;
        check("bp_second_val", 32'(wb_val), 32'd1);
        check("bp_second_waddr", 32'(wb_waddr), 32'd2);
        check("bp_second_data", wb_data, 32'h00c0ffee);
        tick();
        check("bp_empty_after", 32'(wb_val), 32'd0);

        // Empty queue: result held until a tag appears
        check("empty_outstanding", 32'(outstanding), 32'd0);
        muldivresp_val = 1'b1;
        muldivresp_msg_result = 64'h00000055_00000066;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("empty_resp_rdy", 32'(muldivresp_rdy), 32'd0);
            tick();
        end
        exp_q.push_back({5'd9, 32'h00000066});
        tag_val = 1'b1;
        tag_waddr = 5'd9;
        tag_sel = 1'b0;
        @(negedge clk);
        check("empty_no_bypass", 32'(muldivresp_rdy), 32'd0);
        tick();
        tag_val = 1'b0;
        @(negedge clk);
        check("empty_tag_visible", 32'(muldivresp_rdy), 32'd1);
        tick();
        muldivresp_val = 1'b0;
        tick();

        // Reset mid-stream
        wb_rdy = 1'b0;
        do_tag(5'd16, 1'b0);
        do_tag(5'd17, 1'b0);
        do_tag(5'd18, 1'b0);
        do_tag(5'd19, 1'b0);
        do_resp(64'h00000001_00000002, 1'b0, 5'd0, 32'd0, w);
        check("mid_wb_val", 32'(wb_val), 32'd1);
        check("mid_outstanding", 32'(outstanding), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        tick();
        wb_rdy = 1'b1;
        do_tag(5'd6, 1'b1);
        do_resp(64'h00000077_00000088, 1'b1, 5'd6, 32'h00000077, w);
        check("post_reset_wait", 32'(w), 32'd0);
        tick();
        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pv2byp_muldiv_wb_queue.md
# pv2byp_muldiv_wb_queue

Pairs in-order 64-bit results from the pipelined multiply/divide unit with the writeback tags recorded when each request was issued. Delivers one 32-bit register-file write per result to the writeback stage. Sits directly downstream of the muldiv response port (`muldivresp_*`) and upstream of the X/W writeback mux in the pv2byp core. Buffers up to `DEPTH` outstanding tags and one formatted result.

## Interface
- `DEPTH`, 4: tag queue entries; power of two, ≥ 2.
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high.
- `tag_val`  in  1  issue stage records a tag; asserted in the same cycle as the matching `muldivreq_val && muldivreq_rdy`.
- `tag_rdy`  out  1  tag queue not full.
- `tag_waddr`  in  5  destination register.
- `tag_sel`  in  1  result half: 0 selects result[31:0] (mul, div, divu quotient); 1 selects result[63:32] (rem, remu remainder).
- `muldivresp_msg_result`  in  64  {hi/remainder, lo/quotient-or-product}.
- `muldivresp_val`  in  1  result valid.
- `muldivresp_rdy`  out  1  block can accept a result.
- `wb_val`  out  1  writeback entry valid.
- `wb_rdy`  in  1  writeback stage accepts.
- `wb_waddr`  out  5  register address.
- `wb_data`  out  32  selected result half.
- `outstanding`  out  $clog2(DEPTH)+1  tags enqueued and not yet paired (queue occupancy).

## Operation
- Tag queue: circular FIFO of {waddr, sel}, with head and tail pointers of $clog2(DEPTH) bits that wrap modulo `DEPTH`, plus a count register.
  - enq = `tag_val && tag_rdy`.
  - deq = response fire.
- `tag_rdy` = (count != DEPTH). It is independent of deq in the same cycle, so there is no full-bypass.
- Output register: {valid, waddr, data}, one entry. It is empty or full; there is no other state.
- `muldivresp_rdy` = (count != 0) && (!wb_val || wb_rdy).
  - The result is only accepted when a head tag exists and the output slot is free or draining this cycle.
- Response fire = `muldivresp_val && muldivresp_rdy`. On fire:
  - output register loads waddr = head.waddr;
  - data = head.sel ? result[63:32] : result[31:0];
  - valid = 1;
  - head advances.
- Output drain = `wb_val && wb_rdy`. With no fire in the same cycle, valid clears. Fire and drain in the same cycle replaces the entry, and valid stays 1.
- Tags written in cycle N become visible at the head in cycle N+1. There is no same-cycle tag-to-response bypass, because the muldiv unit's minimum latency is greater than 1.
- Enq and deq in the same cycle leave count unchanged. Both pointers advance.
- A result with the queue empty is a protocol violation. `muldivresp_rdy` stays 0 and the result is held upstream.
- Outputs are registered. `wb_*` never depends combinationally on `muldivresp_*` or `tag_*`.

## Timing
- Reset values:
  - `tag_rdy` = 1
  - `muldivresp_rdy` = 0
  - `wb_val` = 0
  - `wb_waddr` = 0
  - `wb_data` = 0
  - `outstanding` = 0
  - head, tail and count all 0.
- Reset in mid-operation discards all tags and the buffered result on the next edge. Responses still in flight upstream are the upstream's responsibility (it is reset together with this block).
- Latency: response fire in cycle N gives `wb_val` = 1 in cycle N+1.
- Throughput: one result per cycle while `wb_rdy` = 1 and tags are available.
- `wb_rdy` low holds `wb_val`, `wb_waddr` and `wb_data` stable. While it is low, `muldivresp_rdy` drops after the slot fills.
- `outstanding` updates on the edge following enq/deq. It reaches `DEPTH` when full.

## Test plan
- **Single rem:** tag {waddr=7, sel=1}, then one cycle later result 64'h0000002e_0000000a. Required: `wb_val` the next cycle with waddr=7, data=32'h0000002e.
- **Mixed stream, `wb_rdy` = 1:** tags {3,0}, {4,1}, {5,0}. Results 64'hffffffff_ffffffc0, 64'hffffcc8e_ffffdf75, 64'h0000227f_00012a90 back-to-back. Required writes in order:
  - (3, ffffffc0)
  - (4, ffffcc8e)
  - (5, 00012a90)
  - one per cycle.
- **Full queue:** enqueue 4 tags with no responses.
  - `tag_rdy` = 0 and `outstanding` = 4.
  - A fifth `tag_val` is not accepted.
  - After one pairing, `tag_rdy` returns to 1 the following cycle.
  - Pointer wrap is exercised by 10 more enq/deq pairs, with correct waddr ordering.
- **Backpressure:** hold `wb_rdy` = 0 with 2 tags queued and results valid.
  - The first result is captured, then `muldivresp_rdy` = 0 and wb outputs are stable.
  - Release `wb_rdy`: the second result is accepted in the same cycle as the first drains.
- **Empty queue:** result valid with no tag. `muldivresp_rdy` stays 0. A tag enqueued in cycle N makes `muldivresp_rdy` = 1 in N+1.
- **Reset mid-stream:** assert reset with 3 tags outstanding and `wb_val` = 1. The next cycle shows all reset values, and a new tag/response pair then works normally.
